ci_stream_initiator: RTL and testbench

CI_STREAM_INITIATOR -- requirements
Module: ci_stream_initiator

---
 rtl/ci_stream_initiator.sv | 165 ++++++++++++++++
 tb/tb_ci_stream_initiator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_stream_initiator.sv
// ci_stream_initiator: streams samples to a custom-instruction responder
// (start/done handshake) and queues each returned result in a small FIFO.
// Operations that stay unanswered for TIMEOUT wait cycles are aborted and
// their samples dropped, with a sticky error flag.
module ci_stream_initiator #(
  parameter int TIMEOUT    = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cfg_datab,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        timeout_err,
  output logic [15:0] done_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // Last wait-counter value before it reaches TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    wait_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_next;
  logic [31:0]   head_next;
  logic          pop;
  logic          push;
  logic          in_fire;

  // Handshake decode and next FIFO occupancy/head; a same-cycle pop frees a slot.
  always_comb begin
    pop             = out_valid & out_ready;
    push            = ((state == ISSUE) || (state == WAIT)) && ci_done;
    rd_ptr_inc      = rd_ptr + 1'b1;
    count_after_pop = count - {{(CW-1){1'b0}}, pop};
    count_next      = count_after_pop + {{(CW-1){1'b0}}, push};
    in_ready        = (state == IDLE) && (count_after_pop < DEPTH_C);
    in_fire         = in_valid & in_ready;
    if (count_after_pop == '0) begin
      head_next = ci_result;
    end else if (pop) begin
      head_next = mem[rd_ptr_inc];
    end else begin
      head_next = mem[rd_ptr];
    end
  end

  // Operation sequencer: accept, issue one start pulse, wait for done or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ci_start    <= 1'b0;
      ci_clk_en   <= 1'b0;
      ci_dataa    <= 32'd0;
      ci_datab    <= 32'd0;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
      done_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            ci_dataa  <= in_data;
            ci_datab  <= cfg_datab;
            ci_start  <= 1'b1;
            ci_clk_en <= 1'b1;
            state     <= ISSUE;
          end else begin
            ci_start  <= 1'b0;
            ci_clk_en <= 1'b0;
          end
        end
        ISSUE: begin
          ci_start <= 1'b0;
          wait_cnt <= 8'd0;
          if (ci_done) begin
            done_count <= done_count + 16'd1;
            ci_clk_en  <= 1'b0;
            state      <= IDLE;
          end else begin
            ci_clk_en <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          ci_start <= 1'b0;
          if (ci_done) begin
            // Completion wins even on the cycle the counter would expire.
            done_count <= done_count + 16'd1;
            ci_clk_en  <= 1'b0;
            state      <= IDLE;
          end else if (wait_cnt == TO_LAST) begin
            wait_cnt    <= wait_cnt + 8'd1;
            timeout_err <= 1'b1;
            ci_clk_en   <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
            ci_clk_en <= 1'b1;
          end
        end
        default: begin
          ci_start  <= 1'b0;
          ci_clk_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Result storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ci_result;
    end
  end

  // FIFO pointers, occupancy and the registered head word presented downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        out_data <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_ci_stream_initiator.sv
// Scoreboard bench for ci_stream_initiator: a behavioural responder answers
// each start after a chosen latency; accepted samples push their expected
// result (or nothing, when the latency exceeds TIMEOUT) into a queue that an
// independent output monitor pops and compares.
module tb_ci_stream_initiator;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 4;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] cfg_datab;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [31:0] ci_result = 32'd0;
  logic        ci_done = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;
  logic [15:0] done_count;

  ci_stream_initiator #(.TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_datab(cfg_datab), .ci_clk_en(ci_clk_en),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_result(ci_result), .ci_done(ci_done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .timeout_err(timeout_err),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int lat_q[$];
  int exp_done = 0;
  bit exp_to = 1'b0;
  bit manual_done = 1'b0;
  logic main_ready = 1'b0;
  logic rnd_ready = 1'b0;
  bit rand_mode = 1'b0;
  int m_start, m_en, m_gap, m_last;

  assign out_ready = rand_mode ? rnd_ready : main_ready;

  // What the responder computes from its two operands.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    return (a * 32'd3) ^ {b[15:0], b[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Responder: answers each start after the latency queued for that sample.
  int r_k = 0;
  int r_lat = 0;
  bit r_active = 1'b0;
  always @(negedge clk) begin
    ci_done   = manual_done;
    ci_result = $urandom;
    if (reset) begin
      r_active = 1'b0;
    end else begin
      if (ci_start) begin
        r_active = 1'b1;
        r_k = 0;
        r_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end else if (r_active) begin
        r_k++;
      end
      if (r_active && r_k == r_lat) begin
        ci_done   = 1'b1;
        ci_result = model(ci_dataa, ci_datab);
        r_active  = 1'b0;
      end
    end
  end

  // Random consumer back-pressure.
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  // Output monitor: every consumed word must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h with no result expected", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Offer one sample; on acceptance record its latency and expected outcome.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input int lat);
    bit ok;
    ok = 1'b0;
    in_data = a; cfg_datab = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: sample %h not accepted, expected within 200 cycles", a);
    end else begin
      lat_q.push_back(lat);
      if (lat <= TIMEOUT) begin
        exp_q.push_back(model(a, b));
        exp_done++;
      end else begin
        exp_to = 1'b1;
      end
    end
  endtask

  // Let all work finish and all expected results drain.
  task automatic drain();
    bit done;
    done = 1'b0;
    rand_mode = 1'b0;
    main_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid && exp_q.size() == 0) done = 1'b1;
    end
    check1("drain_complete", done, 1'b1);
    check("done_count", 32'(done_count), 32'(exp_done[15:0]));
    @(posedge clk); #1;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, "_ci_start"}, ci_start, 1'b0);
    check1({tag, "_ci_clk_en"}, ci_clk_en, 1'b0);
    check({tag, "_ci_dataa"}, ci_dataa, 32'd0);
    check({tag, "_ci_datab"}, ci_datab, 32'd0);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_done_count"}, 32'(done_count), 32'd0);
    check1({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; cfg_datab = 32'd0;
    #12;
    check_reset_values("por");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check1("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency-3 responder: start in cycle 1, done in cycle 4, result visible in cycle 5.
    main_ready = 1'b1;
    send(32'h0000_0100, 32'h0000_00AB, 3);
    @(negedge clk);
    check1("c1_ci_start", ci_start, 1'b1);
    check1("c1_ci_clk_en", ci_clk_en, 1'b1);
    check("c1_ci_dataa", ci_dataa, 32'h0000_0100);
    check("c1_ci_datab", ci_datab, 32'h0000_00AB);
    @(negedge clk);
    check1("c2_ci_start", ci_start, 1'b0);
    check1("c2_ci_clk_en", ci_clk_en, 1'b1);
    wait_neg(2);
    check1("c4_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check1("c5_out_valid", out_valid, 1'b1);
    check("c5_done_count", 32'(done_count), 32'd1);
    check1("c5_ci_clk_en", ci_clk_en, 1'b0);
    @(posedge clk); #1;
    drain();

    // Done on the very cycle the counter reaches TIMEOUT is a completion.
    send($urandom, $urandom, TIMEOUT);
    drain();
    check1("boundary_no_timeout", timeout_err, 1'b0);

    // Silent responder: ISSUE plus TIMEOUT wait cycles of clock enable, then abort.
    send($urandom, $urandom, NEVER);
    m_en = 0; m_start = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ci_clk_en) m_en++;
      if (ci_start) m_start++;
    end
    check("timeout_clk_en_cycles", 32'(m_en), 32'(TIMEOUT + 1));
    check("timeout_start_pulses", 32'(m_start), 32'd1);
    check1("timeout_err_set", timeout_err, 1'b1);
    check1("timeout_fifo_empty", out_valid, 1'b0);
    @(posedge clk); #1;
    send($urandom, $urandom, 2);
    drain();
    // One cycle too late: aborts, and the late done lands in IDLE.
    send($urandom, $urandom, TIMEOUT + 1);
    drain();
    check1("timeout_err_sticky", timeout_err, 1'b1);

    // Single-cycle responder: WAIT skipped, issue period no worse than 3 cycles.
    m_start = 0; m_en = 0; m_gap = 0; m_last = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 0);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (ci_clk_en) m_en++;
          if (ci_start) begin
            m_start++;
            if (m_last >= 0 && i - m_last > m_gap) m_gap = i - m_last;
            m_last = i;
          end
        end
      end
    join
    check("fast_starts", 32'(m_start), 32'd6);
    check("fast_clk_en_cycles", 32'(m_en), 32'd6);
    check1("fast_period_le_3", (m_gap <= 3 && m_gap > 0), 1'b1);
    drain();

    // Consumer stalled: four results fill the FIFO and the fifth sample waits.
    main_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, int'($urandom_range(0, 3)));
    in_data = 32'hCAFE_0005; cfg_datab = 32'h1234_5678; in_valid = 1'b1;
    wait_neg(12);
    check1("full_in_ready", in_ready, 1'b0);
    check1("full_out_valid", out_valid, 1'b1);
    check("full_done_count", 32'(done_count), 32'(exp_done[15:0]));
    @(posedge clk); #1 main_ready = 1'b1;
    @(negedge clk);
    check1("pop_frees_slot", in_ready, 1'b1);
    @(posedge clk); #1;
    main_ready = 1'b0; in_valid = 1'b0;
    lat_q.push_back(1);
    exp_q.push_back(model(32'hCAFE_0005, 32'h1234_5678));
    exp_done++;
    wait_neg(6);
    check1("refull_in_ready", in_ready, 1'b0);
    drain();

    // Push and pop in the same cycle with three entries held.
    main_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 0);
    wait_neg(4);
    check1("three_in_ready", in_ready, 1'b1);
    check1("three_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    send($urandom, $urandom, 2);
    @(posedge clk); #1;
    @(posedge clk); #1 main_ready = 1'b1;
    @(posedge clk); #1 main_ready = 1'b0;
    @(negedge clk);
    check1("pushpop_in_ready", in_ready, 1'b1);
    check1("pushpop_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    send($urandom, $urandom, 0);
    wait_neg(4);
    check1("pushpop_now_full", in_ready, 1'b0);
    drain();

    // Randomised traffic with random back-pressure and latencies.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      int lat;
      r = int'($urandom_range(0, 9));
      if (r <= 6) lat = r % 5;
      else if (r == 7) lat = TIMEOUT;
      else if (r == 8) lat = TIMEOUT + 1;
      else lat = NEVER;
      send($urandom, $urandom, lat);
    end
    drain();
    check1("random_timeout_err", timeout_err, exp_to);

    // Reset in WAIT abandons the operation; a late done afterwards is ignored.
    main_ready = 1'b0;
    send($urandom, $urandom, 0);
    send($urandom, $urandom, 0);
    send($urandom, $urandom, NEVER);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_values("wait_reset");
    exp_q.delete(); lat_q.delete(); exp_done = 0; exp_to = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; manual_done = 1'b1; main_ready = 1'b1;
    @(negedge clk);
    check1("rst_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1 manual_done = 1'b0;
    wait_neg(2);
    check1("late_done_no_push", out_valid, 1'b0);
    check("late_done_count", 32'(done_count), 32'd0);
    check1("late_done_no_err", timeout_err, 1'b0);
    @(posedge clk); #1;
    send($urandom, $urandom, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
